// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and imem fetch sequencer feeding the IF/ID boundary.
// Optional MIPS branch delay slot behaviour is enabled by defining PC_FETCH_DELAY_SLOT_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [31:0] jump_instr,
  input  logic [31:0] jump_pcplus4,
  input  logic        branch_en,
  input  logic [31:0] branch_tgt,
  input  logic        jr_en,
  input  logic [31:0] jr_tgt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        addr_err
);

  typedef enum logic [1:0] {BOOT, FETCH, SLOT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        addr_err_q, addr_err_d;

  logic        redir_req;
  logic [31:0] raw_tgt;
  logic [31:0] redir_tgt;
  logic        misaligned;
  logic        deliver;
  logic        consume;
  logic        unused_bits;

  assign unused_bits = ^{jump_instr[31:26], jump_pcplus4[27:0]};

  // Redirect target selection, jr > jump > branch; low address bits are dropped.
  always_comb begin
    redir_req  = jr_en | jump_en | branch_en;
    raw_tgt    = branch_tgt;
    misaligned = 1'b0;
    if (jr_en) begin
      raw_tgt    = jr_tgt;
      misaligned = (jr_tgt[1:0] != 2'b00);
    end else if (jump_en) begin
      raw_tgt = {jump_pcplus4[31:28], jump_instr[25:0], 2'b00};
    end else if (branch_en) begin
      misaligned = (branch_tgt[1:0] != 2'b00);
    end
    redir_tgt = {raw_tgt[31:2], 2'b00};
  end

  assign imem_req  = (state_q != BOOT) && !(if_valid_q && stall);
  assign imem_addr = pc_q;
  assign deliver   = imem_req && imem_ack;
  assign consume   = if_valid_q && !stall;

`ifdef PC_FETCH_DELAY_SLOT_EN
  logic [31:0] slot_tgt_q, slot_tgt_d;

  // Delay slot mode: the instruction after a branch always gets delivered before the target.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    addr_err_d = 1'b0;
    slot_tgt_d = slot_tgt_q;
    flush      = 1'b0;
    if (state_q == BOOT) begin
      state_d = FETCH;
    end else begin
      if (consume) if_valid_d = 1'b0;
      if (deliver) begin
        if_valid_d = 1'b1;
        if_instr_d = imem_rdata;
        if_pc_d    = pc_q;
        pc_d       = pc_q + 32'd4;
      end
      if (state_q == FETCH && redir_req) begin
        addr_err_d = misaligned;
        if (deliver) begin
          pc_d = redir_tgt;
        end else begin
          slot_tgt_d = redir_tgt;
          state_d    = SLOT;
        end
      end else if (state_q == SLOT && deliver) begin
        pc_d    = slot_tgt_q;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_tgt_q <= 32'h0;
    else        slot_tgt_q <= slot_tgt_d;
  end
`else
  // No delay slot: an accepted redirect discards whatever imem returns this cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    addr_err_d = 1'b0;
    flush      = 1'b0;
    if (state_q == BOOT) begin
      state_d = FETCH;
    end else if (redir_req) begin
      pc_d       = redir_tgt;
      flush      = 1'b1;
      if_valid_d = 1'b0;
      addr_err_d = misaligned;
    end else if (deliver) begin
      if_valid_d = 1'b1;
      if_instr_d = imem_rdata;
      if_pc_d    = pc_q;
      pc_d       = pc_q + 32'd4;
    end else if (consume) begin
      if_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign addr_err = addr_err_q;

endmodule
